// File: rtl/voq_scheduler.sv
// voq_scheduler
// Round-robin (iSLIP, single iteration) crossbar scheduler sitting on top of
// the per-ingress virtual output queue units. Each time slot runs
// GRANT -> ACCEPT -> ISSUE -> HOLD(SLOT_CYCLES). It pulses a dequeue on every
// matched ingress and holds the crossbar configuration for the transfer window.
//
// Ports:
//   clk              clock
//   rst_n            asynchronous active-low reset
//   sched_en         level, allows new slots to start
//   voq_empty        bit i*EGRESS_CNT+e : VOQ e of ingress i is empty
//   voq_dequeue_en   one-cycle dequeue pulse per ingress (ISSUE cycle)
//   voq_dequeue_sel  field i : VOQ to dequeue at ingress i
//   xbar_valid       egress e is connected this slot
//   xbar_in_sel      field e : ingress driving egress e
//   slot_start       one-cycle pulse in the GRANT cycle of each slot
//   busy             high in every state except IDLE
module voq_scheduler #(
  parameter int INGRESS_CNT = 4,
  parameter int EGRESS_CNT  = 4,
  parameter int SLOT_CYCLES = 32,
  localparam int IW = (INGRESS_CNT > 1) ? $clog2(INGRESS_CNT) : 1,
  localparam int EW = (EGRESS_CNT > 1) ? $clog2(EGRESS_CNT) : 1,
  localparam int CW = $clog2(SLOT_CYCLES + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sched_en,
  input  logic [INGRESS_CNT*EGRESS_CNT-1:0] voq_empty,
  output logic [INGRESS_CNT-1:0]        voq_dequeue_en,
  output logic [INGRESS_CNT*EW-1:0]     voq_dequeue_sel,
  output logic [EGRESS_CNT-1:0]         xbar_valid,
  output logic [EGRESS_CNT*IW-1:0]      xbar_in_sel,
  output logic                          slot_start,
  output logic                          busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_GRANT  = 3'd1;
  localparam logic [2:0] S_ACCEPT = 3'd2;
  localparam logic [2:0] S_ISSUE  = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;

  logic [2:0]             state;
  logic [CW-1:0]          slot_cnt;

  logic [IW-1:0]          g_ptr   [EGRESS_CNT];
  logic [EW-1:0]          a_ptr   [INGRESS_CNT];

  logic [EGRESS_CNT-1:0]  gnt_valid;
  logic [IW-1:0]          gnt_sel [EGRESS_CNT];
  logic [EGRESS_CNT-1:0]  gnt_valid_d;
  logic [IW-1:0]          gnt_sel_d [EGRESS_CNT];

  logic [INGRESS_CNT-1:0] acc_valid_d;
  logic [EW-1:0]          acc_sel_d [INGRESS_CNT];

  logic [INGRESS_CNT-1:0] in_valid;
  logic [EW-1:0]          in_sel  [INGRESS_CNT];
  logic [EGRESS_CNT-1:0]  eg_valid;
  logic [IW-1:0]          eg_sel  [EGRESS_CNT];

  logic                   xbar_active;

  // Round-robin position: base+off reduced modulo n. base < n and off < n,
  // so one conditional subtraction is enough even for non-power-of-two n.
  function automatic int wrap_add(input int base, input int off, input int n);
    int s;
    s = base + off;
    return (s >= n) ? s - n : s;
  endfunction

  // Grant: each egress takes the first requesting ingress at or after g[e].
  // gnt_valid_d[e] doubles as the "already found" flag for the search.
  always_comb begin
    gnt_valid_d = '0;
    for (int e = 0; e < EGRESS_CNT; e++) begin
      gnt_sel_d[e] = '0;
      for (int k = 0; k < INGRESS_CNT; k++) begin
        if (!gnt_valid_d[e] &&
            !voq_empty[wrap_add(int'(g_ptr[e]), k, INGRESS_CNT)*EGRESS_CNT + e]) begin
          gnt_valid_d[e] = 1'b1;
          gnt_sel_d[e]   = IW'(wrap_add(int'(g_ptr[e]), k, INGRESS_CNT));
        end
      end
    end
  end

  // Accept: each ingress takes the first granting egress at or after a[i].
  always_comb begin
    acc_valid_d = '0;
    for (int i = 0; i < INGRESS_CNT; i++) begin
      acc_sel_d[i] = '0;
      for (int k = 0; k < EGRESS_CNT; k++) begin
        if (!acc_valid_d[i] &&
            gnt_valid[wrap_add(int'(a_ptr[i]), k, EGRESS_CNT)] &&
            gnt_sel[wrap_add(int'(a_ptr[i]), k, EGRESS_CNT)] == IW'(i)) begin
          acc_valid_d[i] = 1'b1;
          acc_sel_d[i]   = EW'(wrap_add(int'(a_ptr[i]), k, EGRESS_CNT));
        end
      end
    end
  end

  // Slot sequencing. sched_en only matters in IDLE and on the last HOLD cycle,
  // so dropping it mid-slot still lets the current transfer finish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      slot_cnt <= '0;
    end else begin
      case (state)
        S_IDLE:   if (sched_en) state <= S_GRANT;
        S_GRANT:  state <= S_ACCEPT;
        S_ACCEPT: state <= S_ISSUE;
        S_ISSUE: begin
          state    <= S_HOLD;
          slot_cnt <= '0;
        end
        S_HOLD: begin
          if (slot_cnt == CW'(SLOT_CYCLES - 1)) begin
            state <= sched_en ? S_GRANT : S_IDLE;
          end else begin
            slot_cnt <= slot_cnt + 1'b1;
          end
        end
        default:  state <= S_IDLE;
      endcase
    end
  end

  // Match registers and iSLIP pointers. Pointers move only for accepted
  // pairs; an ungranted or unaccepted egress keeps its pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_valid <= '0;
      in_valid  <= '0;
      eg_valid  <= '0;
      for (int e = 0; e < EGRESS_CNT; e++) begin
        g_ptr[e]   <= '0;
        gnt_sel[e] <= '0;
        eg_sel[e]  <= '0;
      end
      for (int i = 0; i < INGRESS_CNT; i++) begin
        a_ptr[i]  <= '0;
        in_sel[i] <= '0;
      end
    end else if (state == S_GRANT) begin
      gnt_valid <= gnt_valid_d;
      for (int e = 0; e < EGRESS_CNT; e++) gnt_sel[e] <= gnt_sel_d[e];
    end else if (state == S_ACCEPT) begin
      in_valid <= acc_valid_d;
      eg_valid <= '0;
      for (int e = 0; e < EGRESS_CNT; e++) eg_sel[e] <= '0;
      for (int i = 0; i < INGRESS_CNT; i++) begin
        if (acc_valid_d[i]) begin
          in_sel[i]              <= acc_sel_d[i];
          eg_valid[acc_sel_d[i]] <= 1'b1;
          eg_sel[acc_sel_d[i]]   <= IW'(i);
          g_ptr[acc_sel_d[i]]    <= IW'(wrap_add(i, 1, INGRESS_CNT));
          a_ptr[i]               <= EW'(wrap_add(int'(acc_sel_d[i]), 1, EGRESS_CNT));
        end
      end
    end
  end

  // Output decode: dequeue only in ISSUE, crossbar from ISSUE through HOLD.
  always_comb begin
    xbar_active     = (state == S_ISSUE) || (state == S_HOLD);
    voq_dequeue_en  = (state == S_ISSUE) ? in_valid : '0;
    xbar_valid      = xbar_active ? eg_valid : '0;
    voq_dequeue_sel = '0;
    xbar_in_sel     = '0;
    for (int i = 0; i < INGRESS_CNT; i++) voq_dequeue_sel[i*EW +: EW] = in_sel[i];
    for (int e = 0; e < EGRESS_CNT; e++) begin
      if (xbar_active && eg_valid[e]) xbar_in_sel[e*IW +: IW] = eg_sel[e];
    end
    slot_start = (state == S_GRANT);
    busy       = (state != S_IDLE);
  end

endmodule
